// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the
// output-priority encoding and its decode into pipeline control strobes.
package hazard_pkg;

    typedef enum logic {
        RUN,
        FREEZE
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        PRIO_RESET,
        PRIO_FREEZE,
        PRIO_REDIRECT,
        PRIO_LOADUSE,
        PRIO_NORMAL
    } prio_e;

    typedef struct packed {
        logic pcWrite;
        logic ifIdWrite;
        logic pipeEn;
        logic ifFlush;
        logic idFlush;
        logic exFlush;
    } ctrl_t;

    // A load-use bubble keeps the back half moving but holds PC and IF/ID.
    function automatic ctrl_t prio_ctrl(prio_e prio);
        ctrl_t c;
        c = '0;
        case (prio)
            PRIO_REDIRECT: c = '{pcWrite: 1'b1, ifIdWrite: 1'b1, pipeEn: 1'b1,
                                 ifFlush: 1'b1, idFlush: 1'b1, exFlush: 1'b1};
            PRIO_LOADUSE:  c = '{pcWrite: 1'b0, ifIdWrite: 1'b0, pipeEn: 1'b1,
                                 ifFlush: 1'b0, idFlush: 1'b1, exFlush: 1'b0};
            PRIO_NORMAL:   c = '{pcWrite: 1'b1, ifIdWrite: 1'b1, pipeEn: 1'b1,
                                 ifFlush: 1'b0, idFlush: 1'b0, exFlush: 1'b0};
            default:       c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-detection inputs and pipeline-control outputs between the core
// datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_rs_i;
    logic [4:0]       IF_ID_rt_i;
    logic [4:0]       ID_EX_rt_i;
    logic             ID_EX_MemRead_i;
    logic             redirect_i;
    logic             mem_busy_i;
    logic             PC_Write_o;
    logic             IF_ID_Write_o;
    logic             IF_Flush_o;
    logic             ID_Flush_o;
    logic             EX_Flush_o;
    logic             pipe_en_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             timeout_o;

    modport master (
        output IF_ID_rs_i, IF_ID_rt_i, ID_EX_rt_i, ID_EX_MemRead_i,
               redirect_i, mem_busy_i,
        input  PC_Write_o, IF_ID_Write_o, IF_Flush_o, ID_Flush_o, EX_Flush_o,
               pipe_en_o, stall_cnt_o, flush_cnt_o, timeout_o
    );

    modport slave (
        input  IF_ID_rs_i, IF_ID_rt_i, ID_EX_rt_i, ID_EX_MemRead_i,
               redirect_i, mem_busy_i,
        output PC_Write_o, IF_ID_Write_o, IF_Flush_o, ID_Flush_o, EX_Flush_o,
               pipe_en_o, stall_cnt_o, flush_cnt_o, timeout_o
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc_i and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush controller: Mealy control strobes for load-use
// stalls, MEM-stage redirects and memory-busy freezes, plus statistics.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input logic         clk_i,
    input logic         rst_i,
    hazard_ctrl_if.slave hz
);
    localparam int FRZ_W = $clog2(TIMEOUT + 1);
    localparam logic [FRZ_W-1:0] FRZ_MAX = FRZ_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic             id_v_q, id_v_d;
    logic             ex_v_q, ex_v_d;
    logic             mem_v_q, mem_v_d;
    logic [FRZ_W-1:0] frz_q, frz_d;
    logic             timeout_q, timeout_d;
    logic             lu;
    logic             rd;
    prio_e            prio;
    ctrl_t            ctrl;

    // Hazard detection and priority resolution; reset forces every strobe low.
    always_comb begin
        lu = id_v_q && ex_v_q && hz.ID_EX_MemRead_i
             && (hz.ID_EX_rt_i != REG_ZERO)
             && ((hz.ID_EX_rt_i == hz.IF_ID_rs_i) || (hz.ID_EX_rt_i == hz.IF_ID_rt_i));
        rd = hz.redirect_i && mem_v_q;
        prio = PRIO_NORMAL;
        if (rst_i) begin
            prio = PRIO_RESET;
        end else if (hz.mem_busy_i) begin
            prio = PRIO_FREEZE;
        end else if (rd) begin
            prio = PRIO_REDIRECT;
        end else if (lu) begin
            prio = PRIO_LOADUSE;
        end
        ctrl = prio_ctrl(prio);
    end

    assign hz.PC_Write_o    = ctrl.pcWrite;
    assign hz.IF_ID_Write_o = ctrl.ifIdWrite;
    assign hz.IF_Flush_o    = ctrl.ifFlush;
    assign hz.ID_Flush_o    = ctrl.idFlush;
    assign hz.EX_Flush_o    = ctrl.exFlush;
    assign hz.pipe_en_o     = ctrl.pipeEn;

    always_comb begin
        state_d   = state_q;
        id_v_d    = id_v_q;
        ex_v_d    = ex_v_q;
        mem_v_d   = mem_v_q;
        frz_d     = '0;
        timeout_d = timeout_q;
        case (state_q)
            RUN:     if (hz.mem_busy_i) state_d = FREEZE;
            FREEZE:  if (!hz.mem_busy_i) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (ctrl.pipeEn) begin
            id_v_d  = ctrl.ifFlush ? 1'b0 : (ctrl.ifIdWrite ? 1'b1 : id_v_q);
            ex_v_d  = ctrl.idFlush ? 1'b0 : id_v_q;
            mem_v_d = ctrl.exFlush ? 1'b0 : ex_v_q;
        end
        // frz counts consecutive busy cycles and parks at TIMEOUT.
        if (hz.mem_busy_i) begin
            frz_d = (frz_q == FRZ_MAX) ? frz_q : frz_q + 1'b1;
            if (frz_d == FRZ_MAX) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            id_v_q    <= 1'b0;
            ex_v_q    <= 1'b0;
            mem_v_q   <= 1'b0;
            frz_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_v_q    <= id_v_d;
            ex_v_q    <= ex_v_d;
            mem_v_q   <= mem_v_d;
            frz_q     <= frz_d;
            timeout_q <= timeout_d;
        end
    end

    assign hz.timeout_o = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (prio == PRIO_LOADUSE),
        .cnt_o (hz.stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (prio == PRIO_REDIRECT),
        .cnt_o (hz.flush_cnt_o)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random checks of hazard_ctrl against a slot-occupancy model
// of the pipeline built from the hazard and priority rules.
module tb_hazard_ctrl;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Model state: occupancy of the ID, EX and MEM slots plus statistics.
    bit   slotValid [3];
    int   stallCount;
    int   flushCount;
    int   busyRun;
    bit   timeoutSeen;
    bit   modelKnown;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hzIf ();

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hzIf.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, compare against the model, then advance it.
    task automatic applyStimulus(input bit r, input int rs, input int rt, input int exRt,
                                 input bit memRead, input bit redirect, input bit busy,
                                 input string tag);
        rst                  = r;
        hzIf.IF_ID_rs_i      = 5'(rs);
        hzIf.IF_ID_rt_i      = 5'(rt);
        hzIf.ID_EX_rt_i      = 5'(exRt);
        hzIf.ID_EX_MemRead_i = memRead;
        hzIf.redirect_i      = redirect;
        hzIf.mem_busy_i      = busy;
        #2;
        checkOutput(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        bit       loadUse;
        bit       redirectHit;
        bit [5:0] expCtrl;
        bit [5:0] obsCtrl;
        bit [CNT_W-1:0] expStall;
        bit [CNT_W-1:0] expFlush;
        bit       nId, nEx, nMem;

        loadUse = slotValid[0] && slotValid[1] && hzIf.ID_EX_MemRead_i
                  && (hzIf.ID_EX_rt_i != 0)
                  && (hzIf.ID_EX_rt_i == hzIf.IF_ID_rs_i || hzIf.ID_EX_rt_i == hzIf.IF_ID_rt_i);
        redirectHit = hzIf.redirect_i && slotValid[2];

        // {PC_Write, IF_ID_Write, pipe_en, IF_Flush, ID_Flush, EX_Flush}
        if (rst)                  expCtrl = 6'b000000;
        else if (hzIf.mem_busy_i) expCtrl = 6'b000000;
        else if (redirectHit)     expCtrl = 6'b111111;
        else if (loadUse)         expCtrl = 6'b001010;
        else                      expCtrl = 6'b111000;

        obsCtrl = {hzIf.PC_Write_o, hzIf.IF_ID_Write_o, hzIf.pipe_en_o,
                   hzIf.IF_Flush_o, hzIf.ID_Flush_o, hzIf.EX_Flush_o};
        checks++;
        assert (obsCtrl === expCtrl) else begin
            failures++;
            $error("[TB] FAIL %s ctrl observed=%b expected=%b", tag, obsCtrl, expCtrl);
        end

        if (modelKnown) begin
            expStall = CNT_W'(stallCount);
            expFlush = CNT_W'(flushCount);
            checks++;
            assert (hzIf.stall_cnt_o === expStall) else begin
                failures++;
                $error("[TB] FAIL %s stall_cnt observed=%0d expected=%0d", tag, hzIf.stall_cnt_o, expStall);
            end
            checks++;
            assert (hzIf.flush_cnt_o === expFlush) else begin
                failures++;
                $error("[TB] FAIL %s flush_cnt observed=%0d expected=%0d", tag, hzIf.flush_cnt_o, expFlush);
            end
            checks++;
            assert (hzIf.timeout_o === timeoutSeen) else begin
                failures++;
                $error("[TB] FAIL %s timeout observed=%b expected=%b", tag, hzIf.timeout_o, timeoutSeen);
            end
        end

        if (rst) begin
            slotValid  = '{0, 0, 0};
            stallCount = 0;
            flushCount = 0;
            busyRun    = 0;
            timeoutSeen = 0;
            modelKnown = 1;
        end else begin
            if (expCtrl[3]) begin
                nMem = expCtrl[0] ? 1'b0 : slotValid[1];
                nEx  = expCtrl[1] ? 1'b0 : slotValid[0];
                nId  = expCtrl[2] ? 1'b0 : (expCtrl[4] ? 1'b1 : slotValid[0]);
                slotValid = '{nId, nEx, nMem};
            end
            if (expCtrl == 6'b001010 && stallCount < CNT_MAX) stallCount++;
            if (expCtrl == 6'b111111 && flushCount < CNT_MAX) flushCount++;
            busyRun = hzIf.mem_busy_i ? busyRun + 1 : 0;
            if (busyRun >= TIMEOUT) timeoutSeen = 1;
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        modelKnown = 0;
        slotValid  = '{0, 0, 0};
        stallCount = 0;
        flushCount = 0;
        busyRun    = 0;
        timeoutSeen = 0;

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, "reset0");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, "reset1");
        applyStimulus(0, 2, 0, 2, 1, 1, 0, "firstCycle");
        idle(3, "fill");

        $display("[TB] load-use");
        applyStimulus(0, 2, 5, 2, 1, 0, 0, "loadUseStall");
        applyStimulus(0, 2, 5, 2, 1, 0, 0, "loadUseBubble");
        idle(2, "refill");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, "loadUseRtZero");
        applyStimulus(0, 3, 7, 7, 1, 0, 0, "loadUseRtMatch");

        $display("[TB] redirect");
        idle(3, "refill");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, "redirect");
        applyStimulus(0, 2, 0, 2, 1, 0, 0, "postRedirectNoStall");
        idle(3, "refill");
        applyStimulus(0, 2, 0, 2, 1, 1, 0, "redirectBeatsLoadUse");

        $display("[TB] freeze");
        idle(3, "refill");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, "freezeRedirect");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, "freezeRelease");
        idle(3, "refill");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "freezeThenReset");
        applyStimulus(1, 0, 0, 0, 0, 1, 1, "resetMidFreeze");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "afterResetFreeze");

        $display("[TB] timeout");
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, "timeoutBusy");
        idle(3, "timeoutSticky");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, "timeoutReset");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "timeoutCleared");

        $display("[TB] saturation");
        idle(3, "refill");
        for (int i = 0; i < 40; i++) applyStimulus(0, 4, 1, 4, 1, 0, 0, "saturate");
        idle(2, "saturateHold");

        $display("[TB] random");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, "randReset");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the 5-stage MIPS core. Every cycle it sequences the pipeline-register write enables and the per-stage flush strobes, including the ID-stage flush that zeroes ID/EX control fields. It handles three cases: load-use stalls, MEM-stage redirects (branch taken or jump), and whole-pipe freezes while data memory is busy. It also tracks per-stage valid bits and keeps saturating stall, flush and freeze-timeout statistics.

## Interface
- TIMEOUT, 1023: freeze cycles tolerated before `timeout_o` is raised.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- IF_ID_rs_i  in  5  rs field of the instruction in ID.
- IF_ID_rt_i  in  5  rt field of the instruction in ID.
- ID_EX_rt_i  in  5  rt (load destination) of the instruction in EX.
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- redirect_i  in  1  MEM-stage branch taken or jump; PC mux selects the target.
- mem_busy_i  in  1  data memory not ready; the pipeline must hold.
- PC_Write_o  out  1  PC load enable.
- IF_ID_Write_o  out  1  IF/ID register write enable.
- IF_Flush_o  out  1  zero the IF/ID instruction.
- ID_Flush_o  out  1  zero the ID/EX control fields (bubble).
- EX_Flush_o  out  1  zero the EX/MEM control fields.
- pipe_en_o  out  1  write enable for ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  out  CNT_W  load-use stall count, saturating.
- flush_cnt_o  out  CNT_W  redirect count, saturating.
- timeout_o  out  1  sticky freeze-timeout flag.

## Operation
- State is RUN or FREEZE. Internal registers: valid bits `id_v`, `ex_v`, `mem_v`; freeze counter `frz`.
- Hazard signals:
  - `lu = id_v & ex_v & ID_EX_MemRead_i & (ID_EX_rt_i != 0) & (ID_EX_rt_i == IF_ID_rs_i | ID_EX_rt_i == IF_ID_rt_i)`.
  - `rd = redirect_i & mem_v`.
- Output priority, evaluated combinationally each cycle:
  1. `mem_busy_i` → freeze: PC_Write=0, IF_ID_Write=0, pipe_en=0, all flushes 0.
  2. `rd` → PC_Write=1, IF_ID_Write=1, pipe_en=1, IF/ID/EX_Flush=1.
  3. `lu` → PC_Write=0, IF_ID_Write=0, pipe_en=1, ID_Flush=1.
  4. Otherwise PC_Write=1, IF_ID_Write=1, pipe_en=1, flushes 0.
- Valid-bit update, only when `pipe_en_o=1`:
  - `id_v <= IF_Flush ? 0 : (IF_ID_Write ? 1 : id_v)`.
  - `ex_v <= ID_Flush ? 0 : id_v`.
  - `mem_v <= EX_Flush ? 0 : ex_v`.
  - During a freeze all valid bits hold.
- State transitions:
  - RUN→FREEZE when `mem_busy_i`.
  - FREEZE→RUN on the first cycle `mem_busy_i=0`. That cycle is evaluated normally, so a redirect or load-use held during the freeze is acted on then.
- Counters:
  - `stall_cnt` +1 on each cycle of priority 3.
  - `flush_cnt` +1 on each cycle of priority 2.
  - Both saturate at all-ones; there is no wrap.
  - `frz` +1 per FREEZE cycle, clears in RUN.
  - `timeout_o` sets when `frz == TIMEOUT` while still busy, and stays set until reset.

## Timing
- Control outputs are Mealy (same-cycle). Zero latency from inputs is required, because the hazard must act in the cycle it is detected.
- Counters, valid bits, state and `timeout_o` update at the clock edge and are visible the next cycle.
- While `rst_i=1`:
  - All control outputs are 0.
  - Next edge: state=RUN, valid bits 0, counters 0, `frz`=0, `timeout_o`=0.
- First cycle after reset: `lu` and `rd` are impossible because all valid bits are 0, so PC_Write=1.
- Reset asserted mid-freeze or mid-stall aborts it immediately, with no residual flush.
- Redirect and load-use in the same cycle: the redirect wins, and no stall is counted.
- A load-use stall lasts exactly 1 cycle, since EX becomes a bubble (`ex_v=0`).
- After a redirect, `id_v=ex_v=mem_v=0` for the flushed slots.

## Structure
- Package `hazard_pkg` holds:
  - the state enum (RUN, FREEZE);
  - `REG_ZERO = 5'd0`;
  - the output-priority encoding.
- Sub-module `sat_counter` (parameter W; inputs clk_i, rst_i, inc_i; output cnt_o), instantiated for the stall and flush counters.
- The freeze counter stays inline.

## Test plan
- Reset: hold rst_i 2 cycles → all control outputs 0, both counters 0. First cycle after release: PC_Write=1, IF_ID_Write=1, pipe_en=1.
- Load-use: EX is `lw $2` (MemRead=1, rt=2), ID has rs=2, all valid → exactly 1 cycle with PC_Write=0, IF_ID_Write=0, ID_Flush=1; stall_cnt 0→1. Same stimulus with rt=0 → no stall.
- Redirect: mem_v=1, redirect_i=1 → IF/ID/EX_Flush=1 for 1 cycle; flush_cnt+1. Next cycle: a matching load-use pattern does not stall, because valid bits are 0. Redirect together with load-use in the same cycle → redirect outputs only, stall_cnt unchanged.
- Freeze: mem_busy_i high 3 cycles while redirect_i=1 → 3 cycles of pipe_en=0 with no flushes and counters frozen. The redirect flush fires on cycle 4.
- Timeout (TIMEOUT=8): mem_busy_i held 12 cycles → timeout_o rises after the 8th freeze cycle and stays high after busy drops. It clears only on rst_i.
- Saturation (CNT_W=4): 20 load-use stalls → stall_cnt holds at 15.
